// File: rtl/imm_extend_pipe.sv
// Registered RV32/RV64 immediate generator with valid/ready handshake and optional 2-entry skid buffer.
// Define IMM_ZICSR_EN to decode imm_src 6 as the CSR zimm; otherwise code 6 reports imm_err like code 7.
module imm_extend_pipe #(
   parameter int XLEN = 32,
   parameter bit SKID = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [2:0]      imm_src,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm_ext,
   output logic            imm_err
);

   typedef enum logic [2:0] {
      IMM_I     = 3'd0,
      IMM_J     = 3'd1,
      IMM_U     = 3'd2,
      IMM_B     = 3'd3,
      IMM_S     = 3'd4,
      IMM_SHAMT = 3'd5,
      IMM_ZICSR = 3'd6,
      IMM_RSVD  = 3'd7
   } imm_fmt_e;

   typedef struct packed {
      logic            err;
      logic [XLEN-1:0] imm;
   } entry_t;

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_extend_pipe: XLEN must be 32 or 64");
   end

   logic   s;
   entry_t dec;
   entry_t o_q;
   logic   o_valid_q;
   logic   in_fire;

   assign s       = instr[31];
   assign in_fire = in_valid && in_ready;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      dec.err = 1'b0;
      dec.imm = '0;
      case (imm_src)
         IMM_I:     dec.imm = {{(XLEN-12){s}}, instr[31:20]};
         IMM_J:     dec.imm = {{(XLEN-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U:     dec.imm = {{(XLEN-31){s}}, instr[30:12], 12'b0};
         IMM_B:     dec.imm = {{(XLEN-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_S:     dec.imm = {{(XLEN-12){s}}, instr[31:25], instr[11:7]};
         IMM_SHAMT: dec.imm = (XLEN == 64) ? {{(XLEN-6){1'b0}}, instr[25:20]}
                                           : {{(XLEN-5){1'b0}}, instr[24:20]};
`ifdef IMM_ZICSR_EN
         IMM_ZICSR: dec.imm = {{(XLEN-5){1'b0}}, instr[19:15]};
`endif
         default:   dec.err = 1'b1;
      endcase
   end

   // The opcode field never contributes to an immediate.
   logic unused_opcode;
   assign unused_opcode = &{1'b0, instr[6:0]};

   if (SKID) begin : g_skid
      entry_t k_q;
      logic   k_valid_q;

      // Registered ready: the skid slot absorbs the entry accepted while O stalls.
      assign in_ready = !k_valid_q;

      // NOTE: data registers are reset as well because imm_ext must read 0 straight out of reset.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            o_valid_q <= 1'b0;
            o_q       <= '0;
            k_valid_q <= 1'b0;
            k_q       <= '0;
         end else if (flush) begin
            o_valid_q <= 1'b0;
            k_valid_q <= 1'b0;
         end else if (!o_valid_q || out_ready) begin
            if (k_valid_q) begin
               o_q       <= k_q;
               o_valid_q <= 1'b1;
               k_valid_q <= 1'b0;
            end else begin
               o_valid_q <= in_fire;
               if (in_fire) o_q <= dec;
            end
         end else if (in_fire) begin
            k_q       <= dec;
            k_valid_q <= 1'b1;
         end
      end
   end else begin : g_noskid
      assign in_ready = !o_valid_q || out_ready;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            o_valid_q <= 1'b0;
            o_q       <= '0;
         end else if (flush) begin
            o_valid_q <= 1'b0;
         end else if (in_ready) begin
            o_valid_q <= in_valid;
            if (in_valid) o_q <= dec;
         end
      end
   end

   assign out_valid = o_valid_q;
   assign imm_ext   = o_q.imm;
   assign imm_err   = o_q.err;

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Covers all RV32/RV64 base immediate formats (I, S, B, U, J) plus shift-amount, sign-extended to XLEN.
- Sits between the instruction fetch/decode boundary and the execute operand mux.
- Uses a valid/ready handshake with an optional 2-entry skid buffer, so decode back-pressure never drops or duplicates an immediate.

Parameters:
- XLEN, 32: output width. Legal values are 32 and 64; any other value is an elaboration error.
- SKID, 1: 1 selects the 2-entry skid buffer (fully registered in_ready); 0 selects a single output register (in_ready combinational from out_ready).

Ports:
- clk  input  1  — system clock, rising edge.
- rst  input  1  — asynchronous, active-high reset.
- flush  input  1  — synchronous pipeline flush; discards all held entries.
- in_valid  input  1  — instr/imm_src are valid.
- in_ready  output  1  — block accepts input this cycle.
- instr  input  32  — raw instruction word.
- imm_src  input  3  — immediate format select.
- out_valid  output  1  — imm_ext/imm_err are valid.
- out_ready  input  1  — consumer accepts output this cycle.
- imm_ext  output  XLEN  — extended immediate.
- imm_err  output  1  — imm_src was an unsupported code.

Behaviour:
- Format decode (combinational, then registered); s = instr[31] replicated to XLEN:
  - 0 I: {s, instr[31:20]}
  - 1 J: {s, instr[19:12], instr[20], instr[30:21], 0}
  - 2 U: {s above bit 31, instr[31:12], 12'b0}. For XLEN=64, bits 63:32 equal instr[31].
  - 3 B: {s, instr[7], instr[30:25], instr[11:8], 0}
  - 4 S: {s, instr[31:25], instr[11:7]}
  - 5 SHAMT: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64
  - 6: reserved (see Optional Feature)
  - 7: imm_ext = 0, imm_err = 1
- imm_err is 0 for all supported codes.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Latency: 1 cycle from input transfer to out_valid when the output register is empty or draining.
- Output stability: while out_valid && !out_ready, imm_ext and imm_err hold stable.
- SKID=1 storage: output register O and skid register K, each with its own valid bit.
  - in_ready = !K.valid (registered).
  - On input transfer, if O is empty or draining this cycle, load O (or O takes K's entry first, see below); otherwise load K.
  - When O drains with K full, O <= K, K becomes empty, and in_ready rises the next cycle.
  - Order is strictly FIFO; K is never loaded while full.
  - Simultaneous drain and input with K empty: O takes the new entry, K stays empty.
- SKID=0 storage:
  - in_ready = !out_valid || out_ready.
  - A new entry overwrites O on the same edge that the old entry drains.
- Flush:
  - Takes priority over input and output transfers.
  - Next cycle: O.valid = 0, K.valid = 0, in_ready = 1. An input presented in the flush cycle is discarded.
  - Data registers may hold stale values but are ignored.
- Reset (asynchronous, any time including mid-transfer):
  - out_valid = 0, imm_ext = 0, imm_err = 0, K cleared, in_ready = 1 after release.
  - Entries in flight are lost.

Optional Feature:
- Macro: IMM_ZICSR_EN.
- Defined: imm_src 6 selects the CSR zimm, imm_ext = zero-extended instr[19:15], imm_err = 0.
- Undefined: imm_src 6 behaves as code 7 (imm_ext = 0, imm_err = 1).
- Code 7 is unsupported in both builds.

Test Plan:
1. I-type: instr=0xFFF00093, imm_src=0, out_ready=1 → next cycle out_valid=1, imm_ext=0xFFFFFFFF (XLEN=64: 0xFFFFFFFFFFFFFFFF), imm_err=0.
2. Format sweep at XLEN=32, back-to-back one per cycle, out_ready=1:
   - B 0xFE000EE3 → 0xFFFFFFFC
   - U 0x12345037 → 0x12345000
   - J 0x0080006F → 0x00000008
   - S 0xFE112E23 → 0xFFFFFFFC
   - All appear in order, one per cycle.
3. Back-pressure, SKID=1, out_ready=0, push A (U 0x12345037), B (J 0x0080006F), C:
   - A is held in O, B goes to K, in_ready=0, C is not accepted.
   - Raise out_ready: 0x12345000, then 0x00000008, then C, with in_ready=1 one cycle after the first drain.
4. Flush with O and K full → next cycle out_valid=0, in_ready=1; a subsequent I 0xFFF00093 outputs 0xFFFFFFFF with no stale entry ahead of it.
5. imm_src=7 → imm_ext=0, imm_err=1. imm_src=6, instr=0x0007D073 → with IMM_ZICSR_EN: imm_ext=0x0000000F, imm_err=0; without: imm_ext=0, imm_err=1.
6. Assert rst asynchronously mid-cycle with out_valid=1 → out_valid=0 and imm_ext=0 immediately (before the next edge); in_ready=1 after release.
